// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: SPI display receiver decoding CASET/PASET/RAMWR into pixel writes.
// Optional macro LCD_RX_SWRESET_EN makes command 0x01 restore the window and idle the parser.
module spi_lcd_rx #(
    parameter int X_MAX = 239,
    parameter int Y_MAX = 319
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mosi,
    input  logic        i_dc,
    input  logic        i_cs,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_pix_valid,
    output logic [8:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_color,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

    localparam logic [8:0] XM = 9'(X_MAX);
    localparam logic [8:0] YM = 9'(Y_MAX);

    function automatic logic [8:0] clamp(input logic [15:0] v, input logic [8:0] m);
        return (v > {7'd0, m}) ? m : v[8:0];
    endfunction

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  sr_q;
    logic [2:0]  idx_q;
    logic [7:0]  p0_q, p1_q, p2_q;
    logic [8:0]  xs_q, xe_q, ys_q, ye_q, cx_q, cy_q;
    logic        pend_q;
    logic [7:0]  hi_q;
    logic        cmd_valid_q, pix_valid_q, err_q;
    logic [7:0]  cmd_q;
    logic [8:0]  pix_x_q, pix_y_q;
    logic [15:0] color_q;

    logic       byte_done;
    logic [7:0] byte_w;
    logic [8:0] xe_eff, ye_eff;

    assign byte_done = !i_cs && bit_cnt_q == 3'd7;
    assign byte_w    = {sr_q, i_mosi};
    // An inverted window collapses to a single column/row at the start coordinate.
    assign xe_eff    = (xs_q > xe_q) ? xs_q : xe_q;
    assign ye_eff    = (ys_q > ye_q) ? ys_q : ye_q;

    // Bit assembly, command/parameter parsing and pixel cursor in one registered FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 7'd0;
            idx_q       <= 3'd0;
            p0_q        <= 8'd0;
            p1_q        <= 8'd0;
            p2_q        <= 8'd0;
            xs_q        <= 9'd0;
            xe_q        <= XM;
            ys_q        <= 9'd0;
            ye_q        <= YM;
            cx_q        <= 9'd0;
            cy_q        <= 9'd0;
            pend_q      <= 1'b0;
            hi_q        <= 8'd0;
            cmd_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cmd_q       <= 8'd0;
            pix_x_q     <= 9'd0;
            pix_y_q     <= 9'd0;
            color_q     <= 16'd0;
        end else begin
            cmd_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (i_cs) begin
                bit_cnt_q <= 3'd0;
                err_q     <= bit_cnt_q != 3'd0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                sr_q      <= {sr_q[5:0], i_mosi};
            end
            if (byte_done && !i_dc) begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= byte_w;
                idx_q       <= 3'd0;
                pend_q      <= 1'b0;
                cx_q        <= xs_q;
                cy_q        <= ys_q;
                state_q     <= byte_w == 8'h2A ? CASET :
                               byte_w == 8'h2B ? PASET :
                               byte_w == 8'h2C ? RAMWR : SKIP;
`ifdef LCD_RX_SWRESET_EN
                if (byte_w == 8'h01) begin
                    state_q <= IDLE;
                    xs_q    <= 9'd0;
                    xe_q    <= XM;
                    ys_q    <= 9'd0;
                    ye_q    <= YM;
                end
`endif
            end else if (byte_done) begin
                case (state_q)
                    CASET, PASET: begin
                        if (idx_q != 3'd4) idx_q <= idx_q + 3'd1;
                        case (idx_q)
                            3'd0: p0_q <= byte_w;
                            3'd1: p1_q <= byte_w;
                            3'd2: p2_q <= byte_w;
                            3'd3: begin
                                if (state_q == CASET) begin
                                    xs_q <= clamp({p0_q, p1_q}, XM);
                                    xe_q <= clamp({p2_q, byte_w}, XM);
                                end else begin
                                    ys_q <= clamp({p0_q, p1_q}, YM);
                                    ye_q <= clamp({p2_q, byte_w}, YM);
                                end
                            end
                            default: ;
                        endcase
                    end
                    RAMWR: begin
                        if (!pend_q) begin
                            hi_q   <= byte_w;
                            pend_q <= 1'b1;
                        end else begin
                            pend_q      <= 1'b0;
                            pix_valid_q <= 1'b1;
                            pix_x_q     <= cx_q;
                            pix_y_q     <= cy_q;
                            color_q     <= {hi_q, byte_w};
                            if (cx_q >= xe_eff) begin
                                cx_q <= xs_q;
                                cy_q <= (cy_q >= ye_eff) ? ys_q : cy_q + 9'd1;
                            end else begin
                                cx_q <= cx_q + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_pix_valid = pix_valid_q;
    assign o_pix_x     = pix_x_q;
    assign o_pix_y     = pix_y_q;
    assign o_pix_color = color_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx: directed self-checking bench for spi_lcd_rx.
module tb_spi_lcd_rx;
    logic        clk = 1'b0, rst = 1'b1, mosi = 1'b0, dc = 1'b0, cs = 1'b1;
    logic        o_cmd_valid, o_pix_valid, o_err;
    logic [7:0]  o_cmd;
    logic [8:0]  o_pix_x, o_pix_y;
    logic [15:0] o_pix_color;

    spi_lcd_rx dut (
        .i_clk(clk), .i_rst(rst), .i_mosi(mosi), .i_dc(dc), .i_cs(cs),
        .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_pix_valid(o_pix_valid),
        .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_color(o_pix_color), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int np = 0, ncmd = 0, nerr = 0;
    bit tog = 1'b0;
    logic [8:0]  px [256];
    logic [8:0]  py [256];
    logic [15:0] pc [256];
    longint      pt [256];
    logic [7:0]  last_cmd = 8'h00;

    // Event monitor: records every output pulse on the falling edge.
    always @(negedge clk) begin
        if (o_pix_valid && np < 256) begin
            px[np] = o_pix_x; py[np] = o_pix_y; pc[np] = o_pix_color; pt[np] = $time;
            np++;
        end
        if (o_cmd_valid) begin ncmd++; last_cmd = o_cmd; end
        if (o_err) nerr++;
    end

    task automatic gap(input int n);
        repeat (n) begin @(negedge clk); cs = 1'b1; end
    endtask

    task automatic send_bits(input bit d, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk); cs = 1'b0; dc = d; mosi = b[i];
        end
        if (tog) gap(1);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; cs = 1'b1; mosi = 1'b0; dc = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int b;
        do_reset();
        tests++;
        if ({o_cmd_valid, o_pix_valid, o_err, o_cmd, o_pix_x, o_pix_y, o_pix_color} !== 45'd0) begin
            fails++; $display("FAIL reset_outputs got %h want 0",
                {o_cmd_valid, o_pix_valid, o_err, o_cmd, o_pix_x, o_pix_y, o_pix_color});
        end
        b = np;
        dat(8'h12); dat(8'h34); gap(2);
        tests++;
        if (np - b !== 0) begin fails++; $display("FAIL idle_ignores_data got %0d pixels want 0", np - b); end
    endtask

    task automatic test_first_pixel();
        int b, c;
        do_reset();
        b = np; c = ncmd;
        cmd(8'h2C);
        @(negedge clk); cs = 1'b1;
        tests++;
        if (o_cmd_valid !== 1'b1 || o_cmd !== 8'h2C) begin
            fails++; $display("FAIL cmd_pulse_timing got v=%b cmd=%h want 1/2c", o_cmd_valid, o_cmd);
        end
        dat(8'hF8); dat(8'h00);
        @(negedge clk); cs = 1'b1;
        tests++;
        if (o_pix_valid !== 1'b1) begin fails++; $display("FAIL pix_pulse_timing got %b want 1", o_pix_valid); end
        gap(2);
        tests++;
        if (ncmd - c !== 1 || last_cmd !== 8'h2C || o_cmd !== 8'h2C) begin
            fails++; $display("FAIL cmd_once got n=%0d cmd=%h want 1/2c", ncmd - c, o_cmd);
        end
        tests++;
        if (np - b !== 1 || px[b] !== 9'd0 || py[b] !== 9'd0 || pc[b] !== 16'hF800) begin
            fails++; $display("FAIL first_pixel got n=%0d x=%0d y=%0d c=%h want 1/0/0/f800",
                np - b, px[b], py[b], pc[b]);
        end
    endtask

    task automatic stream(input bit t, input string name);
        int b, ex, ey;
        do_reset();
        tog = t;
        cmd(8'h2A); dat(8'h00); dat(8'h0C); dat(8'h00); dat(8'h12);
        cmd(8'h2B); dat(8'h00); dat(8'h09); dat(8'h00); dat(8'h0A);
        b = np;
        cmd(8'h2C);
        for (int k = 0; k < 8; k++) begin dat(8'(k + 1)); dat(8'h5A ^ 8'(k)); end
        tog = 1'b0;
        gap(3);
        tests++;
        if (np - b !== 8) begin fails++; $display("FAIL %s_count got %0d want 8", name, np - b); end
        for (int k = 0; k < 8; k++) begin
            ex = (k < 7) ? 12 + k : 12;
            ey = (k < 7) ? 9 : 10;
            tests++;
            if (px[b+k] !== 9'(ex) || py[b+k] !== 9'(ey) || pc[b+k] !== {8'(k + 1), 8'h5A ^ 8'(k)}) begin
                fails++; $display("FAIL %s_pix%0d got x=%0d y=%0d c=%h want %0d/%0d/%h", name, k,
                    px[b+k], py[b+k], pc[b+k], ex, ey, {8'(k + 1), 8'h5A ^ 8'(k)});
            end
            if (!t && k > 0) begin
                tests++;
                if (pt[b+k] - pt[b+k-1] !== 64'd160) begin
                    fails++; $display("FAIL %s_rate%0d got %0d want 160", name, k, pt[b+k] - pt[b+k-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stream(1'b0, "held");
    endtask

    task automatic test_cs_toggle();
        stream(1'b1, "toggled");
    endtask

    task automatic test_clamp();
        int b;
        do_reset();
        cmd(8'h2A); dat(8'h01); dat(8'h2C); dat(8'h01); dat(8'h2C);
        cmd(8'h2B); dat(8'h01); dat(8'h40); dat(8'h01); dat(8'h40);
        b = np;
        cmd(8'h2C); dat(8'h12); dat(8'h34); gap(2);
        tests++;
        if (np - b !== 1 || px[b] !== 9'd239 || py[b] !== 9'd319) begin
            fails++; $display("FAIL clamp got n=%0d x=%0d y=%0d want 1/239/319", np - b, px[b], py[b]);
        end
    endtask

    task automatic test_wrap();
        int b;
        logic [8:0] ex [7];
        logic [8:0] ey [7];
        ex = '{9'd0, 9'd1, 9'd0, 9'd5, 9'd5, 9'd5, 9'd5};
        ey = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd0, 9'd0};
        do_reset();
        b = np;
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'hFF); dat(8'hFF);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
        cmd(8'h2C); repeat (3) begin dat(8'hAA); dat(8'h55); end
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h03);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        cmd(8'h2C); repeat (3) begin dat(8'hAA); dat(8'h55); end
        cmd(8'h2A); dat(8'h00); dat(8'h07);
        cmd(8'h2C); dat(8'hAA); dat(8'h55);
        gap(2);
        tests++;
        if (np - b !== 7) begin fails++; $display("FAIL wrap_count got %0d want 7", np - b); end
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (px[b+k] !== ex[k] || py[b+k] !== ey[k]) begin
                fails++; $display("FAIL wrap_pix%0d got x=%0d y=%0d want %0d/%0d", k,
                    px[b+k], py[b+k], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_err();
        int b, e;
        do_reset();
        cmd(8'h2C);
        b = np; e = nerr;
        send_bits(1'b1, 8'hAB, 5);
        gap(3);
        tests++;
        if (nerr - e !== 1 || np - b !== 0) begin
            fails++; $display("FAIL partial_err got err=%0d pix=%0d want 1/0", nerr - e, np - b);
        end
        dat(8'h12); dat(8'h34); gap(2);
        tests++;
        if (np - b !== 1 || pc[b] !== 16'h1234 || px[b] !== 9'd0 || nerr - e !== 1) begin
            fails++; $display("FAIL after_err got n=%0d c=%h x=%0d err=%0d want 1/1234/0/1",
                np - b, pc[b], px[b], nerr - e);
        end
        dat(8'hAB); cmd(8'h2C); dat(8'h56); dat(8'h78); gap(2);
        tests++;
        if (np - b !== 2 || pc[b+1] !== 16'h5678 || px[b+1] !== 9'd0) begin
            fails++; $display("FAIL drop_pending_hi got n=%0d c=%h x=%0d want 2/5678/0",
                np - b, pc[b+1], px[b+1]);
        end
    endtask

    task automatic test_rst_mid();
        int b, e;
        do_reset();
        cmd(8'h2C); dat(8'hF8);
        b = np; e = nerr;
        send_bits(1'b1, 8'h00, 4);
        @(negedge clk); rst = 1'b1; cs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (np - b !== 0 || nerr - e !== 0 || o_cmd !== 8'h00) begin
            fails++; $display("FAIL reset_mid_byte got pix=%0d err=%0d cmd=%h want 0/0/00", np - b, nerr - e, o_cmd);
        end
        dat(8'h12); dat(8'h34); gap(2);
        tests++;
        if (np - b !== 0) begin fails++; $display("FAIL reset_to_idle got %0d pixels want 0", np - b); end
    endtask

    task automatic test_swreset();
        int b, c;
        logic [8:0] wx;
`ifdef LCD_RX_SWRESET_EN
        wx = 9'd0;
`else
        wx = 9'd5;
`endif
        do_reset();
        b = np; c = ncmd;
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h01); cmd(8'h2C); dat(8'h07); dat(8'hE0); gap(2);
        tests++;
        if (np - b !== 1 || px[b] !== wx || py[b] !== 9'd0 || ncmd - c !== 3) begin
            fails++; $display("FAIL swreset got n=%0d x=%0d y=%0d cmds=%0d want 1/%0d/0/3",
                np - b, px[b], py[b], ncmd - c, wx);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_back_to_back();
        test_cs_toggle();
        test_clamp();
        test_wrap();
        test_err();
        test_rst_mid();
        test_swreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_lcd_rx.md
# spi_lcd_rx

Synthesizable display-side receiver for the 4-wire SPI link our drawing blocks drive: samples MOSI/DC/CS, assembles MSB-first bytes, and decodes the ILI9341 subset we emit. The subset is CASET 0x2A, PASET 0x2B and RAMWR 0x2C. It outputs one registered pixel write (x, y, RGB565) per received pixel. It sits opposite a drawing master as a loopback checker or a frame-buffer front end.

## Interface
- X_MAX, 239, highest legal column; window column registers clamp to it.
- Y_MAX, 319, highest legal row; window row registers clamp to it.
- i_clk  input  1  system clock; also the serial bit clock, one bit per cycle while i_cs is low.
- i_rst  input  1  synchronous, active-high reset.
- i_mosi  input  1  serial data, MSB first.
- i_dc  input  1  0 = command byte, 1 = data byte; sampled with each byte's last bit.
- i_cs  input  1  active-low chip select.
- o_cmd_valid  output  1  one-cycle pulse per received command byte.
- o_cmd  output  8  last command byte; holds until the next command.
- o_pix_valid  output  1  one-cycle pulse per decoded pixel.
- o_pix_x  output  9  column of the pixel.
- o_pix_y  output  9  row of the pixel.
- o_pix_color  output  16  RGB565, high byte first on the wire.
- o_err  output  1  one-cycle pulse when a partial byte is discarded.

## Operation
- Bit counter 0..7 and an 8-bit shift register advance on every cycle with i_cs=0.
- Byte completes when bit 7 is sampled; i_dc is sampled on that same cycle.
- i_cs=1 clears the bit counter. If the count was non-zero, the partial byte is discarded and o_err pulses.
- Parser state persists across i_cs toggles, so masters that toggle CS per byte are supported.
- Parser states and transitions:
  - IDLE: data bytes are ignored.
  - CASET: collects 4 data bytes: XS_hi, XS_lo, XE_hi, XE_lo.
  - PASET: same four-byte sequence for YS/YE.
  - RAMWR: alternates pixel high byte, then low byte.
  - SKIP: any other command; data bytes are ignored.
- Any command byte moves the parser to the matching state, resets the parameter index, clears any pending pixel high byte, and pulses o_cmd_valid.
- CASET/PASET registers:
  - Take the 16-bit values, keep the lower bits, and clamp to X_MAX/Y_MAX.
  - Commit only after the 4th byte; an interrupted sequence leaves the window unchanged.
  - Bytes beyond the 4th are ignored; the parser stays in state.
- RAMWR cursor:
  - Set to (XS, YS) on entry.
  - After each pixel, x increments; at XE, x returns to XS and y increments.
  - At (XE, YE) the cursor wraps to (XS, YS).
  - If XS>XE, treat XE as XS (single column); rows use the same rule.
- Window defaults at reset: XS=0, XE=X_MAX, YS=0, YE=Y_MAX.

## Timing
- Reset values: all pulse outputs 0, o_cmd=0x00, o_pix_x=0, o_pix_y=0, o_pix_color=0. Parser is in IDLE, bit counter is 0, window is at defaults.
- o_cmd_valid asserts one cycle after the cycle that samples bit 7 of a command byte.
- o_pix_valid asserts one cycle after the cycle that samples bit 7 of the pixel low byte.
- x/y/color are stable whenever o_pix_valid=1.
- Back-to-back bytes with CS held low give a throughput of one pixel per 16 cycles; no stall path exists.
- o_err asserts one cycle after the cycle on which i_cs rises with a partial byte.
- i_rst mid-byte or mid-command: state returns to reset values the next cycle, and no pulse is emitted for the aborted byte.
- Command byte with a pending pixel high byte: the high byte is dropped silently.

## Configuration
- LCD_RX_SWRESET_EN defined: command 0x01 (SWRESET) restores window defaults and returns the parser to IDLE; o_cmd_valid still pulses.
- LCD_RX_SWRESET_EN undefined: 0x01 is handled like any unknown command (SKIP); the window is unchanged.

## Test plan
- Reset, then send command 0x2C with CS low and data 0xF8,0x00 -> o_cmd_valid once with o_cmd=0x2C; o_pix_valid once with x=0, y=0, color=0xF800.
- Send CASET 0x00,0x0C,0x00,0x12; PASET 0x00,0x09,0x00,0x0A; RAMWR with 8 pixels -> pixels at x=12..18 on y=9, then x=12 on y=10.
- Send CASET 0x01,0x2C,0x01,0x2C, RAMWR, 1 pixel -> x clamped to 239.
- Raise i_cs after 5 bits of a data byte -> o_err pulses once, no pixel is emitted, and the next full byte decodes correctly.
- Toggle CS between every byte of a RAMWR stream -> the pixel sequence is identical to the CS-held-low case.
- With LCD_RX_SWRESET_EN: after CASET to 5..6, send 0x01, RAMWR, 1 pixel -> x=0, y=0. Without the macro: x=5.
